// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives the ECP5 PLL reset, waits for a stable lock,
// releases the core and panel reset domains in order, recovers from lock
// loss, and arbitrates dynamic phase steps onto the PLL phase-step pins.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RELEASE_GAP         = 64,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned STEP_PULSE_CYCLES   = 4,
  parameter int unsigned STEP_GAP_CYCLES     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       panel_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  input  logic       phase_req,
  input  logic [1:0] phase_sel,
  input  logic       phase_dir,
  output logic       phase_ack,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One shared phase counter, wide enough for the longest interval.
  localparam int unsigned CNT_MAX = max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                              max2(LOCK_STABLE_CYCLES, RELEASE_GAP)),
                                         max2(STEP_PULSE_CYCLES, STEP_GAP_CYCLES));
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = 4;

  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   REL_LAST   = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(STEP_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SGAP_LAST  = CNT_W'(STEP_GAP_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RELEASE,
    S_RUN,
    S_STEP_PULSE,
    S_STEP_GAP,
    S_FAULT
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
  logic [1:0]           sync_q;
  logic                 locked_s;
  logic                 pll_rst_q, pll_rst_d;
  logic                 core_q, core_d;
  logic                 panel_q, panel_d;
  logic                 ready_q, ready_d;
  logic                 fault_q, fault_d;
  logic                 ack_q, ack_d;
  logic [1:0]           sel_q, sel_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 lock_lost;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  // Saturating increments: counters never wrap.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      core_q    <= 1'b1;
      panel_q   <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      ack_q     <= 1'b0;
      sel_q     <= 2'b00;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      core_q    <= core_d;
      panel_q   <= panel_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      ack_q     <= ack_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
    end
  end

  // Next-state and next-output logic; lock loss from the released states
  // is folded into one common override applied after the case.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    core_d    = core_q;
    panel_d   = panel_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    ack_d     = 1'b0;
    sel_d     = sel_q;
    dir_d     = dir_q;
    step_d    = step_q;
    lock_lost = 1'b0;

    unique case (state_q)
      S_RESET_PLL: begin
        pll_rst_d = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAULT;
            core_d  = 1'b1;
            panel_d = 1'b1;
            ready_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            state_d = S_RESET_PLL;
            retry_d = retry_inc;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_STABILIZE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          core_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RELEASE: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          panel_d = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RUN: begin
        // A request seen on the ack cycle is the one just serviced.
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (phase_req && !ack_q) begin
          state_d = S_STEP_PULSE;
          cnt_d   = '0;
          sel_d   = phase_sel;
          dir_d   = phase_dir;
          step_d  = 1'b1;
        end
      end

      S_STEP_PULSE: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (cnt_q == PULSE_LAST) begin
          state_d = S_STEP_GAP;
          cnt_d   = '0;
          step_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_STEP_GAP: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (cnt_q == SGAP_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_FAULT: begin
        pll_rst_d = 1'b1;
        core_d    = 1'b1;
        panel_d   = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b1;
      end

      default: begin
        state_d   = S_RESET_PLL;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
      end
    endcase

    // Lock dropped after release: re-enter reset, abort any step, no ack.
    if (lock_lost) begin
      state_d   = S_RESET_PLL;
      cnt_d     = '0;
      retry_d   = '0;
      pll_rst_d = 1'b1;
      core_d    = 1'b1;
      panel_d   = 1'b1;
      ready_d   = 1'b0;
      ack_d     = 1'b0;
      step_d    = 1'b0;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign core_reset    = core_q;
  assign panel_reset   = panel_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_count   = retry_q;
  assign phase_ack     = ack_q;
  assign pll_phasesel  = sel_q;
  assign pll_phasedir  = dir_q;
  assign pll_phasestep = step_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: self-checking bench for pll_reset_sequencer.
module tb_pll_reset_sequencer;

  localparam int unsigned P_RST   = 4;
  localparam int unsigned P_TMO   = 32;
  localparam int unsigned P_STB   = 8;
  localparam int unsigned P_GAP   = 4;
  localparam int unsigned P_RETRY = 2;
  localparam int unsigned P_PULSE = 2;
  localparam int unsigned P_SGAP  = 3;

  localparam int W_RST   = 0;
  localparam int W_CORE  = 1;
  localparam int W_PANEL = 2;
  localparam int W_READY = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       phase_req = 1'b0;
  logic [1:0] phase_sel = 2'd0;
  logic       phase_dir = 1'b0;
  logic       pll_rst, core_reset, panel_reset, ready, fault, phase_ack;
  logic [3:0] retry_count;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir, pll_phasestep;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_TIMEOUT_CYCLES (P_TMO),
    .LOCK_STABLE_CYCLES  (P_STB),
    .RELEASE_GAP         (P_GAP),
    .MAX_RETRIES         (P_RETRY),
    .STEP_PULSE_CYCLES   (P_PULSE),
    .STEP_GAP_CYCLES     (P_SGAP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .core_reset    (core_reset),
    .panel_reset   (panel_reset),
    .ready         (ready),
    .fault         (fault),
    .retry_count   (retry_count),
    .phase_req     (phase_req),
    .phase_sel     (phase_sel),
    .phase_dir     (phase_dir),
    .phase_ack     (phase_ack),
    .pll_phasesel  (pll_phasesel),
    .pll_phasedir  (pll_phasedir),
    .pll_phasestep (pll_phasestep)
  );

  always #5 clock = ~clock;

  // Bit order: rst core panel rdy flt rc[3:0] ack sel[1:0] dir stp
  typedef struct packed {
    logic       rst;
    logic       core;
    logic       panel;
    logic       rdy;
    logic       flt;
    logic [3:0] rc;
    logic       ack;
    logic [1:0] sel;
    logic       dir;
    logic       stp;
  } outs_t;

  typedef struct {
    string      name;
    logic       req;
    logic [1:0] sel;
    logic       dir;
    logic       lock;
    outs_t      exp;
  } vec_t;

  typedef struct {
    string name;
    outs_t exp;
  } sb_t;

  sb_t   sb_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  outs_t r_exp;
  vec_t  tbl[27];

  function automatic outs_t mk(input logic rst, input logic core, input logic panel,
                               input logic rdy, input logic flt, input logic [3:0] rc,
                               input logic ack, input logic [1:0] sel, input logic dir,
                               input logic stp);
    outs_t o;
    o.rst = rst; o.core = core; o.panel = panel; o.rdy = rdy; o.flt = flt;
    o.rc = rc; o.ack = ack; o.sel = sel; o.dir = dir; o.stp = stp;
    return o;
  endfunction

  // Expected outputs while released and locked.
  function automatic outs_t run(input logic ack, input logic [1:0] sel, input logic dir,
                                input logic stp);
    return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, ack, sel, dir, stp);
  endfunction

  function automatic vec_t mkv(input string name, input logic req, input logic [1:0] sel,
                               input logic dir, input logic lock, input outs_t exp);
    vec_t v;
    v.name = name; v.req = req; v.sel = sel; v.dir = dir; v.lock = lock; v.exp = exp;
    return v;
  endfunction

  function automatic outs_t cur();
    return mk(pll_rst, core_reset, panel_reset, ready, fault, retry_count,
              phase_ack, pll_phasesel, pll_phasedir, pll_phasestep);
  endfunction

  function automatic logic sig_of(input int w);
    case (w)
      W_RST:   return pll_rst;
      W_CORE:  return core_reset;
      W_PANEL: return panel_reset;
      default: return ready;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t got;
    got = cur();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (rst core panel rdy flt rc ack sel dir stp)",
               name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic sb_push(input string name, input outs_t exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check_outs(e.name, e.exp);
    end
  endtask

  // Cycles until signal w equals v; -1 if the budget runs out.
  task automatic count_until(input int w, input logic v, input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (sig_of(w) !== v && n < limit);
    if (sig_of(w) !== v) n = -1;
  endtask

  // Release reset with lock already present and wait for ready.
  task automatic bring_up(input string name);
    int n;
    reset      = 1'b0;
    pll_locked = 1'b1;
    count_until(W_READY, 1'b1, 200, n);
    check_int(name, n, int'(P_RST + 1 + P_STB + P_GAP));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t, falls, rises, fall1, rise1, rc_r1, rc_r2;
    logic prev, step_seen;

    r_exp = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0);

    // Phase-step sequences in RUN, then lock loss mid-step.
    tbl[0]  = mkv("step1_pulse0", 1'b1, 2'd2, 1'b1, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b1));
    tbl[1]  = mkv("step1_pulse1", 1'b1, 2'd2, 1'b1, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b1));
    tbl[2]  = mkv("step1_gap0",   1'b1, 2'd2, 1'b1, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b0));
    tbl[3]  = mkv("step1_gap1",   1'b1, 2'd2, 1'b1, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b0));
    tbl[4]  = mkv("step1_gap2",   1'b1, 2'd2, 1'b1, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b0));
    tbl[5]  = mkv("step1_ack",    1'b1, 2'd2, 1'b1, 1'b1, run(1'b1, 2'd2, 1'b1, 1'b0));
    tbl[6]  = mkv("step1_ackend", 1'b0, 2'd2, 1'b1, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b0));
    tbl[7]  = mkv("hold_sel0",    1'b0, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b0));
    tbl[8]  = mkv("hold_sel1",    1'b0, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd2, 1'b1, 1'b0));
    tbl[9]  = mkv("step2_pulse0", 1'b1, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd1, 1'b0, 1'b1));
    tbl[10] = mkv("step2_pulse1", 1'b1, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd1, 1'b0, 1'b1));
    tbl[11] = mkv("step2_gap0",   1'b1, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd1, 1'b0, 1'b0));
    tbl[12] = mkv("step2_gap1",   1'b1, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd1, 1'b0, 1'b0));
    tbl[13] = mkv("step2_gap2",   1'b1, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd1, 1'b0, 1'b0));
    tbl[14] = mkv("step2_ack",    1'b1, 2'd1, 1'b0, 1'b1, run(1'b1, 2'd1, 1'b0, 1'b0));
    tbl[15] = mkv("ack_cyc_ign",  1'b1, 2'd1, 1'b0, 1'b1, run(1'b0, 2'd1, 1'b0, 1'b0));
    tbl[16] = mkv("step3_pulse0", 1'b1, 2'd3, 1'b1, 1'b1, run(1'b0, 2'd3, 1'b1, 1'b1));
    tbl[17] = mkv("step3_pulse1", 1'b0, 2'd0, 1'b0, 1'b1, run(1'b0, 2'd3, 1'b1, 1'b1));
    tbl[18] = mkv("step3_gap0",   1'b0, 2'd0, 1'b0, 1'b1, run(1'b0, 2'd3, 1'b1, 1'b0));
    tbl[19] = mkv("step3_gap1",   1'b0, 2'd0, 1'b0, 1'b1, run(1'b0, 2'd3, 1'b1, 1'b0));
    tbl[20] = mkv("step3_gap2",   1'b0, 2'd0, 1'b0, 1'b1, run(1'b0, 2'd3, 1'b1, 1'b0));
    tbl[21] = mkv("step3_ack",    1'b0, 2'd0, 1'b0, 1'b1, run(1'b1, 2'd3, 1'b1, 1'b0));
    tbl[22] = mkv("step3_idle",   1'b0, 2'd0, 1'b0, 1'b1, run(1'b0, 2'd3, 1'b1, 1'b0));
    tbl[23] = mkv("abort_pulse0", 1'b1, 2'd0, 1'b0, 1'b1, run(1'b0, 2'd0, 1'b0, 1'b1));
    tbl[24] = mkv("abort_pulse1", 1'b0, 2'd0, 1'b0, 1'b0, run(1'b0, 2'd0, 1'b0, 1'b1));
    tbl[25] = mkv("abort_gap0",   1'b0, 2'd0, 1'b0, 1'b0, run(1'b0, 2'd0, 1'b0, 1'b0));
    tbl[26] = mkv("abort_reset",  1'b0, 2'd0, 1'b0, 1'b0, r_exp);

    // Reset values.
    repeat (3) cyc();
    check_outs("reset_values", r_exp);

    // Power-up with lock arriving 5 cycles after pll_rst falls.
    reset = 1'b0;
    count_until(W_RST, 1'b0, 20, n);
    check_int("pwr_pll_rst_len", n, int'(P_RST));
    repeat (5) cyc();
    pll_locked = 1'b1;
    count_until(W_CORE, 1'b0, 40, n);
    check_int("pwr_core_release", n, 3 + int'(P_STB));
    count_until(W_PANEL, 1'b0, 20, n);
    check_int("pwr_panel_gap", n, int'(P_GAP));
    check_outs("pwr_run", run(1'b0, 2'd0, 1'b0, 1'b0));

    // Table: phase steps and lock loss mid-step.
    foreach (tbl[i]) begin
      phase_req  = tbl[i].req;
      phase_sel  = tbl[i].sel;
      phase_dir  = tbl[i].dir;
      pll_locked = tbl[i].lock;
      sb_push(tbl[i].name, tbl[i].exp);
      cyc();
      sb_pop_check();
    end

    count_until(W_RST, 1'b0, 20, n);
    check_int("abort_pll_rst_len", n, int'(P_RST));

    // Glitchy lock during STABILIZE restarts the stable count.
    pll_locked = 1'b1;
    repeat (5) cyc();
    pll_locked = 1'b0;
    cyc();
    pll_locked = 1'b1;
    count_until(W_CORE, 1'b0, 40, n);
    check_int("glitch_core_release", n, 3 + int'(P_STB));
    check_int("glitch_no_pll_rst", int'(pll_rst), 0);
    count_until(W_PANEL, 1'b0, 20, n);
    check_int("glitch_panel_gap", n, int'(P_GAP));
    check_outs("reseq_run", run(1'b0, 2'd0, 1'b0, 1'b0));

    // Asynchronous reset during STEP_PULSE.
    phase_req = 1'b1; phase_sel = 2'd1; phase_dir = 1'b1;
    cyc();
    check_int("pre_reset_step", int'(pll_phasestep), 1);
    reset = 1'b1;
    #2;
    check_outs("areset_pulse", r_exp);
    phase_req = 1'b0;
    cyc(); cyc();
    bring_up("bringup_after_pulse");

    // Asynchronous reset during STEP_GAP.
    phase_req = 1'b1; phase_sel = 2'd2; phase_dir = 1'b0;
    cyc();
    phase_req = 1'b0;
    cyc(); cyc();
    check_outs("in_gap", run(1'b0, 2'd2, 1'b0, 1'b0));
    reset = 1'b1;
    #2;
    check_outs("areset_gap", r_exp);
    cyc(); cyc();

    // Asynchronous reset during RELEASE.
    reset = 1'b0;
    count_until(W_CORE, 1'b0, 40, n);
    check_int("rel_core_release", n, int'(P_RST + 1 + P_STB));
    check_outs("in_release", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    reset = 1'b1;
    #2;
    check_outs("areset_release", r_exp);
    cyc(); cyc();

    // Never locks: retries, then sticky FAULT; requests ignored throughout.
    pll_locked = 1'b0;
    phase_req = 1'b1; phase_sel = 2'd3; phase_dir = 1'b1;
    reset = 1'b0;
    t = 0; falls = 0; rises = 0; fall1 = -1; rise1 = -1; rc_r1 = -1; rc_r2 = -1;
    prev = 1'b1; step_seen = 1'b0;
    while (fault !== 1'b1 && t < 400) begin
      cyc();
      t++;
      if (pll_phasestep || phase_ack) step_seen = 1'b1;
      if (prev && !pll_rst) begin
        falls++;
        if (falls == 1) fall1 = t;
      end
      if (!prev && pll_rst) begin
        rises++;
        if (rises == 1) begin
          rise1 = t;
          rc_r1 = int'(retry_count);
        end
        if (rises == 2) rc_r2 = int'(retry_count);
      end
      prev = pll_rst;
    end
    check_int("fault_reached", int'(fault), 1);
    check_int("retry_pulses", falls, 3);
    check_int("lock_timeout_len", rise1 - fall1, int'(P_TMO));
    check_int("retry_after_1st", rc_r1, 1);
    check_int("retry_after_2nd", rc_r2, 2);
    check_int("no_step_outside_run", int'(step_seen), 0);
    check_outs("fault_state", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0));
    pll_locked = 1'b1;
    repeat (30) cyc();
    check_outs("fault_sticky", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0, 1'b0));
    reset = 1'b1;
    #2;
    check_outs("fault_cleared", r_exp);
    phase_req = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
